// File: rtl/zmod_link_align_if.sv
// Handshake/bus bundle between the ZMOD link-align sequencer and its surroundings.
// The slave modport is the sequencer; the master side drives start and the deserialized words.
interface zmod_link_align_if #(
   parameter int unsigned NLANE = 4,
   parameter int unsigned DW    = 8,
   parameter int unsigned TAPW  = 5
);
   localparam int unsigned LNW = (NLANE > 1) ? $clog2(NLANE) : 1;

   logic                   start;
   logic [NLANE*DW-1:0]    rx_data;
   logic                   train_en;
   logic [NLANE-1:0]       bitslip;
   logic [NLANE-1:0]       tap_ld;
   logic [NLANE*TAPW-1:0]  tap_val;
   logic                   busy;
   logic                   aligned;
   logic                   fail;
   logic [LNW-1:0]         fail_lane;

   modport master (
      output start, rx_data,
      input  train_en, bitslip, tap_ld, tap_val, busy, aligned, fail, fail_lane
   );

   modport slave (
      input  start, rx_data,
      output train_en, bitslip, tap_ld, tap_val, busy, aligned, fail, fail_lane
   );
endinterface

// File: rtl/zmod_link_align.sv
// Link-training sequencer: aligns each received LVDS lane in turn with bitslips and
// input-delay tap steps until the training word is seen MATCH_CNT times in a row.
module zmod_link_align #(
   parameter int unsigned    NLANE     = 4,
   parameter int unsigned    DW        = 8,
   parameter logic [DW-1:0]  PATTERN   = DW'(8'h6A),
   parameter int unsigned    TAPW      = 5,
   parameter int unsigned    SETTLE    = 16,
   parameter int unsigned    MATCH_CNT = 64
) (
   input  logic              clk,
   input  logic              resetn,
   zmod_link_align_if.slave  bus
);

   localparam int unsigned LNW = (NLANE > 1) ? $clog2(NLANE) : 1;
   localparam int unsigned SPW = $clog2(DW + 1);
   localparam int unsigned STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int unsigned MCW = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;
   localparam logic [TAPW-1:0] TAP_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_SETTLE, S_CHECK, S_SLIP, S_TAP, S_DONE, S_FAIL
   } state_t;

   state_t                 state_q;
   logic [LNW-1:0]         ln_q;
   logic [SPW-1:0]         slip_q;
   logic [MCW-1:0]         match_q;
   logic [STW-1:0]         settle_q;
   logic [NLANE*TAPW-1:0]  tap_q;
   logic [NLANE-1:0]       bitslip_q;
   logic [NLANE-1:0]       tap_ld_q;
   logic                   busy_q;
   logic                   train_q;
   logic                   aligned_q;
   logic                   fail_q;
   logic [LNW-1:0]         fail_lane_q;

   logic [DW-1:0]          lane_word_c;
   logic [TAPW-1:0]        cur_tap_c;
   logic                   hit_c;

   // Word and tap of the lane currently being trained.
   always_comb begin
      lane_word_c = '0;
      cur_tap_c   = '0;
      for (int i = 0; i < int'(NLANE); i++) begin
         if (ln_q == LNW'(i)) begin
            lane_word_c = bus.rx_data[i*DW +: DW];
            cur_tap_c   = tap_q[i*TAPW +: TAPW];
         end
      end
      hit_c = (lane_word_c == PATTERN);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         ln_q        <= '0;
         slip_q      <= '0;
         match_q     <= '0;
         settle_q    <= '0;
         tap_q       <= '0;
         bitslip_q   <= '0;
         tap_ld_q    <= '0;
         busy_q      <= 1'b0;
         train_q     <= 1'b0;
         aligned_q   <= 1'b0;
         fail_q      <= 1'b0;
         fail_lane_q <= '0;
      end else begin
         bitslip_q <= '0;
         tap_ld_q  <= '0;
         case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
               if (bus.start) begin
                  state_q     <= S_INIT;
                  aligned_q   <= 1'b0;
                  fail_q      <= 1'b0;
                  fail_lane_q <= '0;
                  ln_q        <= '0;
                  slip_q      <= '0;
                  tap_q       <= '0;
                  tap_ld_q    <= '1;
                  busy_q      <= 1'b1;
                  train_q     <= 1'b1;
               end
            end
            S_INIT: begin
               state_q  <= S_SETTLE;
               settle_q <= '0;
            end
            S_SETTLE: begin
               if (settle_q == STW'(SETTLE - 1)) begin
                  state_q  <= S_CHECK;
                  settle_q <= '0;
                  match_q  <= '0;
               end else begin
                  settle_q <= settle_q + STW'(1);
               end
            end
            S_CHECK: begin
               if (hit_c) begin
                  if (match_q == MCW'(MATCH_CNT - 1)) begin
                     if (ln_q == LNW'(NLANE - 1)) begin
                        state_q   <= S_DONE;
                        aligned_q <= 1'b1;
                        busy_q    <= 1'b0;
                        train_q   <= 1'b0;
                     end else begin
                        state_q  <= S_SETTLE;
                        ln_q     <= ln_q + LNW'(1);
                        slip_q   <= '0;
                        settle_q <= '0;
                     end
                  end else begin
                     match_q <= match_q + MCW'(1);
                  end
               end else if (slip_q < SPW'(DW)) begin
                  state_q   <= S_SLIP;
                  bitslip_q <= NLANE'(1) << ln_q;
                  slip_q    <= slip_q + SPW'(1);
               end else if (cur_tap_c != TAP_MAX) begin
                  // All DW slip positions tried at this tap: step the delay line.
                  state_q  <= S_TAP;
                  tap_ld_q <= NLANE'(1) << ln_q;
                  slip_q   <= '0;
                  for (int i = 0; i < int'(NLANE); i++) begin
                     if (ln_q == LNW'(i)) tap_q[i*TAPW +: TAPW] <= cur_tap_c + TAPW'(1);
                  end
               end else begin
                  state_q     <= S_FAIL;
                  fail_q      <= 1'b1;
                  fail_lane_q <= ln_q;
                  busy_q      <= 1'b0;
                  train_q     <= 1'b0;
               end
            end
            S_SLIP, S_TAP: begin
               state_q  <= S_SETTLE;
               settle_q <= '0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.train_en  = train_q;
   assign bus.bitslip   = bitslip_q;
   assign bus.tap_ld    = tap_ld_q;
   assign bus.tap_val   = tap_q;
   assign bus.busy      = busy_q;
   assign bus.aligned   = aligned_q;
   assign bus.fail      = fail_q;
   assign bus.fail_lane = fail_lane_q;

endmodule
